// File: rtl/vga_sync_monitor_if.sv
// Sync pair into the VGA sync monitor and its measurement/status outputs.
// master drives the sync lines; slave is the monitor.
interface vga_sync_monitor_if;
  logic        H_SYNC_IN;
  logic        V_SYNC_IN;
  logic [10:0] PIX_X;
  logic [9:0]  PIX_Y;
  logic [10:0] H_PERIOD;
  logic        H_ERR;
  logic        V_ERR;
  logic        LOCKED;

  modport master (
    output H_SYNC_IN, V_SYNC_IN,
    input  PIX_X, PIX_Y, H_PERIOD, H_ERR, V_ERR, LOCKED
  );

  modport slave (
    input  H_SYNC_IN, V_SYNC_IN,
    output PIX_X, PIX_Y, H_PERIOD, H_ERR, V_ERR, LOCKED
  );
endinterface

// File: rtl/vga_sync_monitor.sv
// Receive-side VGA sync checker: measures H/V timing against the configured
// pattern, reconstructs pixel coordinates and reports lock after clean frames.
module vga_sync_monitor #(
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned H_PULSE     = 96,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned V_PULSE     = 2,
  parameter int unsigned LOCK_FRAMES = 3
) (
  input logic               CLK,
  input logic               NRST,
  vga_sync_monitor_if.slave bus
);
  localparam int unsigned HW  = 11;
  localparam int unsigned VW  = 10;
  localparam int unsigned VSW = VW + 1;
  localparam int unsigned GW  = 3;

  localparam logic [HW-1:0]  H_MAX    = '1;
  localparam logic [VW-1:0]  V_MAX    = '1;
  localparam logic [HW-1:0]  H_END    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]  H_PW_END = HW'(H_PULSE - 1);
  localparam logic [HW-1:0]  H_TO_PRE = HW'(2 * H_TOTAL - 2);
  localparam logic [VSW-1:0] V_LINES  = VSW'(V_TOTAL);
  localparam logic [VSW-1:0] V_PW     = VSW'(V_PULSE);
  localparam logic [GW-1:0]  G_LOCK   = GW'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCK    = 2'd2
  } state_t;

  logic [2:0]     h_sr, v_sr;
  logic           hfall, hrise, vfall, vrise;
  logic [HW-1:0]  h_cnt, h_period;
  logic [VW-1:0]  v_cnt;
  logic           h_seen;
  logic [VSW-1:0] v_lines;
  logic           h_viol, v_viol, any_viol, frame_ok;
  state_t         state, state_d;
  logic [GW-1:0]  gcnt, gcnt_d;
  logic           dirty, dirty_d;
  logic           h_err_q, h_err_d, v_err_q, v_err_d, locked_q, locked_d;

  // Two synchronizer stages plus one edge-detect stage per sync line
  always_ff @(posedge CLK or posedge NRST) begin
    if (NRST) begin
      h_sr <= '1;
      v_sr <= '1;
    end else begin
      h_sr <= {h_sr[1:0], bus.H_SYNC_IN};
      v_sr <= {v_sr[1:0], bus.V_SYNC_IN};
    end
  end

  assign hfall = h_sr[2] & ~h_sr[1];
  assign hrise = ~h_sr[2] & h_sr[1];
  assign vfall = v_sr[2] & ~v_sr[1];
  assign vrise = ~v_sr[2] & v_sr[1];

  // A coincident hfall belongs to the frame that vfall closes
  assign v_lines = {1'b0, v_cnt} + VSW'(hfall);

  // Timeout is raised on the edge h_cnt reaches 2*H_TOTAL-1; only an hfall can rearm it
  assign h_viol = (hfall && h_seen && (h_cnt != H_END))
               || (hrise && (h_cnt != H_PW_END))
               || (!hfall && (h_cnt == H_TO_PRE));
  assign v_viol = (vfall && (v_lines != V_LINES))
               || (vrise && (v_lines != V_PW));
  assign any_viol = h_viol | v_viol;
  assign frame_ok = vfall & ~dirty & ~any_viol;

  // Position counters and line period measurement, all saturating
  always_ff @(posedge CLK or posedge NRST) begin
    if (NRST) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      h_period <= '0;
      h_seen   <= 1'b0;
    end else begin
      if (hfall) begin
        h_cnt  <= '0;
        h_seen <= 1'b1;
        if (h_seen) h_period <= (h_cnt == H_MAX) ? H_MAX : h_cnt + HW'(1);
      end else if (h_cnt != H_MAX) begin
        h_cnt <= h_cnt + HW'(1);
      end
      if (vfall) v_cnt <= '0;
      else if (hfall && (v_cnt != V_MAX)) v_cnt <= v_cnt + VW'(1);
    end
  end

  always_ff @(posedge CLK or posedge NRST) begin
    if (NRST) begin
      state    <= ST_SEARCH;
      gcnt     <= '0;
      dirty    <= 1'b0;
      h_err_q  <= 1'b0;
      v_err_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state    <= state_d;
      gcnt     <= gcnt_d;
      dirty    <= dirty_d;
      h_err_q  <= h_err_d;
      v_err_q  <= v_err_d;
      locked_q <= locked_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_SEARCH:  if (vfall) state_d = ST_ACQUIRE;
      ST_ACQUIRE: if (frame_ok && ((gcnt + GW'(1)) == G_LOCK)) state_d = ST_LOCK;
      ST_LOCK:    if (any_viol) state_d = ST_SEARCH;
      default:    state_d = ST_SEARCH;
    endcase
  end

  // Errors are only reported once the stream has been acquired
  always_comb begin
    gcnt_d   = gcnt;
    dirty_d  = dirty | any_viol;
    h_err_d  = 1'b0;
    v_err_d  = 1'b0;
    locked_d = (state_d == ST_LOCK);
    case (state)
      ST_SEARCH: begin
        if (vfall) begin
          gcnt_d  = '0;
          dirty_d = 1'b0;
        end
      end
      ST_ACQUIRE: begin
        h_err_d = h_viol;
        v_err_d = v_viol;
        if (any_viol) gcnt_d = '0;
        else if (frame_ok) gcnt_d = gcnt + GW'(1);
        if (vfall) dirty_d = 1'b0;
      end
      ST_LOCK: begin
        h_err_d = h_viol;
        v_err_d = v_viol;
        if (any_viol) gcnt_d = '0;
        if (vfall) dirty_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.PIX_X    = h_cnt;
  assign bus.PIX_Y    = v_cnt;
  assign bus.H_PERIOD = h_period;
  assign bus.H_ERR    = h_err_q;
  assign bus.V_ERR    = v_err_q;
  assign bus.LOCKED   = locked_q;
endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor on a scaled timing (40/6/10/2, lock after 3).
// Pin changes land on negedges; outputs for an event show 3 cycles later.
module tb_vga_sync_monitor;
  localparam int HT = 40;
  localparam int HP = 6;
  localparam int VT = 10;
  localparam int VP = 2;
  localparam int LF = 3;

  logic CLK = 1'b0;
  logic NRST = 1'b1;
  vga_sync_monitor_if bus();

  vga_sync_monitor #(
    .H_TOTAL(HT), .H_PULSE(HP), .V_TOTAL(VT), .V_PULSE(VP), .LOCK_FRAMES(LF)
  ) dut (
    .CLK(CLK),
    .NRST(NRST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Observation of DUT status outputs
  int n_herr = 0, n_verr = 0;
  int herr_cyc = -1, herr_x = -1, herr_locked = -1, herr_period = -1;
  int verr_cyc = -1, verr_locked = -1;
  int lock_cyc = -1;
  int herr_run = 0, verr_run = 0, herr_run_max = 0, verr_run_max = 0;
  int max_x = 0, max_y = 0;
  logic locked_prev = 1'b0;

  always @(negedge CLK) begin
    locked_prev <= bus.LOCKED;
    if (bus.LOCKED && !locked_prev) lock_cyc <= cyc;
    if (bus.H_ERR) begin
      n_herr      <= n_herr + 1;
      herr_cyc    <= cyc;
      herr_x      <= int'(bus.PIX_X);
      herr_locked <= int'(bus.LOCKED);
      herr_period <= int'(bus.H_PERIOD);
    end
    if (bus.V_ERR) begin
      n_verr      <= n_verr + 1;
      verr_cyc    <= cyc;
      verr_locked <= int'(bus.LOCKED);
    end
    herr_run <= bus.H_ERR ? herr_run + 1 : 0;
    verr_run <= bus.V_ERR ? verr_run + 1 : 0;
    if (bus.H_ERR && (herr_run + 1 > herr_run_max)) herr_run_max <= herr_run + 1;
    if (bus.V_ERR && (verr_run + 1 > verr_run_max)) verr_run_max <= verr_run + 1;
    if (int'(bus.PIX_X) > max_x) max_x <= int'(bus.PIX_X);
    if (int'(bus.PIX_Y) > max_y) max_y <= int'(bus.PIX_Y);
  end

  // Stream driver bookkeeping
  int vf_q[$];
  int line_cyc = 0, hr_cyc = 0, vr_cyc = 0;

  task automatic drive_line(input int len, input int pw, input bit vlow);
    @(negedge CLK);
    line_cyc = cyc;
    if (vlow && bus.V_SYNC_IN) vf_q.push_back(cyc);
    if (!vlow && !bus.V_SYNC_IN) vr_cyc = cyc;
    bus.H_SYNC_IN = 1'b0;
    bus.V_SYNC_IN = !vlow;
    repeat (pw) @(negedge CLK);
    hr_cyc = cyc;
    bus.H_SYNC_IN = 1'b1;
    repeat (len - pw - 1) @(negedge CLK);
  endtask

  task automatic drive_frame(input int lines, input int vp);
    for (int i = 0; i < lines; i++) drive_line(HT, HP, i < vp);
  endtask

  int base, mark, herr0, verr0;

  initial begin
    bus.H_SYNC_IN = 1'b1;
    bus.V_SYNC_IN = 1'b1;
    repeat (4) @(negedge CLK);
    check_eq("rst_pix_x", int'(bus.PIX_X), 0);
    check_eq("rst_pix_y", int'(bus.PIX_Y), 0);
    check_eq("rst_h_period", int'(bus.H_PERIOD), 0);
    check_eq("rst_h_err", int'(bus.H_ERR), 0);
    check_eq("rst_v_err", int'(bus.V_ERR), 0);
    check_eq("rst_locked", int'(bus.LOCKED), 0);
    NRST = 1'b0;

    // Nominal stream: lock at the 4th vfall
    repeat (5) drive_frame(VT, VP);
    check_eq("nom_lock_cyc", lock_cyc, vf_q[3] + 3);
    check_eq("nom_locked", int'(bus.LOCKED), 1);
    check_eq("nom_herr_cnt", n_herr, 0);
    check_eq("nom_verr_cnt", n_verr, 0);
    check_eq("nom_h_period", int'(bus.H_PERIOD), HT);
    check_eq("nom_max_x", max_x, HT - 1);
    check_eq("nom_max_y", max_y, VT - 1);

    // One short line while locked
    herr0 = n_herr;
    verr0 = n_verr;
    for (int i = 0; i < VT; i++) begin
      drive_line((i == 5) ? HT - 1 : HT, HP, i < VP);
      if (i == 6) mark = line_cyc;
    end
    check_eq("short_herr_cyc", herr_cyc, mark + 3);
    check_eq("short_herr_locked", herr_locked, 0);
    check_eq("short_h_period", herr_period, HT - 1);
    base = vf_q.size();
    repeat (4) drive_frame(VT, VP);
    check_eq("short_relock_cyc", lock_cyc, vf_q[base + 3] + 3);
    check_eq("short_herr_cnt", n_herr - herr0, 1);
    check_eq("short_verr_cnt", n_verr - verr0, 0);

    // H_SYNC stuck high while locked: one timeout, then saturation
    herr0 = n_herr;
    for (int i = 0; i < VT; i++) begin
      if (i == 3) begin
        drive_line(2150, HP, 1'b0);
        mark = line_cyc;
        check_eq("stuck_pix_x_sat", int'(bus.PIX_X), 2047);
      end else begin
        drive_line(HT, HP, i < VP);
      end
      if (i == 4) check_eq("stuck_h_period_sat", int'(bus.H_PERIOD), 2047);
    end
    check_eq("stuck_herr_cnt", n_herr - herr0, 1);
    check_eq("stuck_herr_x", herr_x, 2 * HT - 1);
    check_eq("stuck_herr_cyc", herr_cyc, mark + 3 + 2 * HT - 1);
    check_eq("stuck_herr_locked", herr_locked, 0);
    check_eq("stuck_locked", int'(bus.LOCKED), 0);

    // Short frame in ACQUIRE with two good frames counted
    verr0 = n_verr;
    base = vf_q.size();
    drive_frame(VT, VP);
    drive_frame(VT, VP);
    drive_frame(VT - 1, VP);
    repeat (4) drive_frame(VT, VP);
    check_eq("vshort_verr_cyc", verr_cyc, vf_q[base + 3] + 3);
    check_eq("vshort_verr_cnt", n_verr - verr0, 1);
    check_eq("vshort_lock_cyc", lock_cyc, vf_q[base + 6] + 3);
    check_eq("vshort_locked", int'(bus.LOCKED), 1);

    // V pulse one line too long while locked
    verr0 = n_verr;
    drive_frame(VT, VP + 1);
    check_eq("vpw_verr_cyc", verr_cyc, vr_cyc + 3);
    check_eq("vpw_verr_cnt", n_verr - verr0, 1);
    check_eq("vpw_verr_locked", verr_locked, 0);
    base = vf_q.size();
    repeat (4) drive_frame(VT, VP);
    check_eq("vpw_relock_cyc", lock_cyc, vf_q[base + 3] + 3);

    // H pulse one cycle short while locked
    herr0 = n_herr;
    verr0 = n_verr;
    for (int i = 0; i < VT; i++) begin
      drive_line(HT, (i == 2) ? HP - 1 : HP, i < VP);
      if (i == 2) mark = hr_cyc;
    end
    check_eq("hpw_herr_cyc", herr_cyc, mark + 3);
    check_eq("hpw_herr_cnt", n_herr - herr0, 1);
    check_eq("hpw_verr_cnt", n_verr - verr0, 0);
    check_eq("hpw_herr_locked", herr_locked, 0);
    check_eq("herr_pulse_width", herr_run_max, 1);
    check_eq("verr_pulse_width", verr_run_max, 1);

    // Relock, then reset mid-line
    base = vf_q.size();
    repeat (4) drive_frame(VT, VP);
    check_eq("pre_rst_lock_cyc", lock_cyc, vf_q[base + 3] + 3);
    @(negedge CLK);
    bus.H_SYNC_IN = 1'b0;
    repeat (10) @(negedge CLK);
    NRST = 1'b1;
    #1;
    check_eq("arst_pix_x", int'(bus.PIX_X), 0);
    check_eq("arst_pix_y", int'(bus.PIX_Y), 0);
    check_eq("arst_h_period", int'(bus.H_PERIOD), 0);
    check_eq("arst_h_err", int'(bus.H_ERR), 0);
    check_eq("arst_v_err", int'(bus.V_ERR), 0);
    check_eq("arst_locked", int'(bus.LOCKED), 0);
    bus.H_SYNC_IN = 1'b1;
    bus.V_SYNC_IN = 1'b1;
    repeat (2) @(negedge CLK);
    NRST = 1'b0;
    herr0 = n_herr;
    verr0 = n_verr;
    base = vf_q.size();
    repeat (5) drive_frame(VT, VP);
    check_eq("post_rst_lock_cyc", lock_cyc, vf_q[base + 3] + 3);
    check_eq("post_rst_herr_cnt", n_herr - herr0, 0);
    check_eq("post_rst_verr_cnt", n_verr - verr0, 0);
    check_eq("post_rst_h_period", int'(bus.H_PERIOD), HT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
